// File: rtl/ro_response_gen.sv
// Ring-oscillator PUF response generator.
// Per challenge: settle the RO-pair mux with the oscillators off, count edges of
// both ROs over a fixed window, then store (cnt_a > cnt_b) as one response bit.
// Challenge 0 becomes the MSB. start_out pulses once the full word is assembled.
module ro_response_gen #(
  parameter int DATA_BITS = 64,
  parameter int SEL_BITS  = 6,
  parameter int CNT_BITS  = 16,
  parameter int WINDOW    = 1024,
  parameter int SETTLE    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 ro_a_edge,
  input  logic                 ro_b_edge,
  output logic [SEL_BITS-1:0]  sel,
  output logic                 ro_en,
  output logic                 busy,
  output logic                 start_out,
  output logic [DATA_BITS-1:0] response
);

  // One timer serves both the settle and measurement phases.
  localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_MEASURE = 3'd2,
    S_COMPARE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [TMR_W-1:0]    tmr;
  logic [CNT_BITS-1:0] cnt_a, cnt_b;
  logic                settle_end, window_end, last_sel;
  logic [SEL_BITS-1:0] bit_idx;

  assign settle_end = (tmr == TMR_W'(SETTLE - 1));
  assign window_end = (tmr == TMR_W'(WINDOW - 1));
  assign last_sel   = (sel == SEL_BITS'(DATA_BITS - 1));
  // Challenge 0 lands in the MSB so the serializer sends it first.
  assign bit_idx    = SEL_BITS'(DATA_BITS - 1) - sel;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and Moore outputs; illegal encodings fall back to IDLE.
  always_comb begin
    state_nxt = state;
    ro_en     = 1'b0;
    busy      = 1'b1;
    start_out = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_SETTLE;
      end
      S_SETTLE:  if (settle_end) state_nxt = S_MEASURE;
      S_MEASURE: begin
        ro_en = 1'b1;
        if (window_end) state_nxt = S_COMPARE;
      end
      S_COMPARE: state_nxt = last_sel ? S_DONE : S_SETTLE;
      S_DONE: begin
        start_out = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: phase timer, saturating edge counters, challenge index, response word.
  // Counters are cleared before each SETTLE so they read 0 until MEASURE starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr      <= '0;
      cnt_a    <= '0;
      cnt_b    <= '0;
      sel      <= '0;
      response <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            tmr      <= '0;
            cnt_a    <= '0;
            cnt_b    <= '0;
            sel      <= '0;
            response <= '0;
          end
        end
        S_SETTLE: tmr <= settle_end ? '0 : tmr + TMR_W'(1);
        S_MEASURE: begin
          tmr <= window_end ? '0 : tmr + TMR_W'(1);
          if (ro_a_edge && (cnt_a != '1)) cnt_a <= cnt_a + CNT_BITS'(1);
          if (ro_b_edge && (cnt_b != '1)) cnt_b <= cnt_b + CNT_BITS'(1);
        end
        S_COMPARE: begin
          // Compares the registered counts from the last MEASURE cycle; tie -> 0.
          response[bit_idx] <= (cnt_a > cnt_b);
          if (!last_sel) begin
            sel   <= sel + SEL_BITS'(1);
            cnt_a <= '0;
            cnt_b <= '0;
          end
        end
        S_DONE: sel <= '0;
        default: begin
          tmr      <= '0;
          cnt_a    <= '0;
          cnt_b    <= '0;
          sel      <= '0;
          response <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ro_response_gen.sv
// Bench for ro_response_gen: two instances (CNT_BITS 4 and 2) share stimulus.
// Edge inputs are recorded per cycle; the expected word is recomputed from the
// recorded edges over each challenge's measurement window with plain arithmetic.
module tb_ro_response_gen;
  localparam int DB  = 8;
  localparam int SB  = 3;
  localparam int W   = 8;
  localparam int S   = 2;
  localparam int PER = S + W + 1;   // cycles per challenge
  localparam int RUN = DB * PER;    // offset of the DONE cycle after the start edge

  logic clk = 1'b0;
  logic rst, start, ro_a_edge, ro_b_edge;
  logic [SB-1:0] sel4, sel2;
  logic ro_en4, ro_en2, busy4, busy2, so4, so2;
  logic [DB-1:0] resp4, resp2;

  always #5 clk = ~clk;

  ro_response_gen #(.DATA_BITS(DB), .SEL_BITS(SB), .CNT_BITS(4), .WINDOW(W), .SETTLE(S)) u4 (
    .clk(clk), .rst(rst), .start(start), .ro_a_edge(ro_a_edge), .ro_b_edge(ro_b_edge),
    .sel(sel4), .ro_en(ro_en4), .busy(busy4), .start_out(so4), .response(resp4));

  ro_response_gen #(.DATA_BITS(DB), .SEL_BITS(SB), .CNT_BITS(2), .WINDOW(W), .SETTLE(S)) u2 (
    .clk(clk), .rst(rst), .start(start), .ro_a_edge(ro_a_edge), .ro_b_edge(ro_b_edge),
    .sel(sel2), .ro_en(ro_en2), .busy(busy2), .start_out(so2), .response(resp2));

  int vec = 0;
  int err = 0;

  bit ea [RUN];
  bit eb [RUN];

  // Observations of the last run.
  int            o_done_t, o_busy, o_ctrl_bad;
  logic [DB-1:0] o_r4, o_r2, o_clr4, o_clr2;
  logic          o_idle_ok;

  // Reference: count edges in each window, clip at counter max, compare.
  function automatic logic [DB-1:0] model(input int cmax);
    logic [DB-1:0] r;
    int ca, cb;
    r = '0;
    for (int j = 0; j < DB; j++) begin
      ca = 0;
      cb = 0;
      for (int p = S; p < S + W; p++) begin
        ca += int'(ea[j*PER+p]);
        cb += int'(eb[j*PER+p]);
      end
      if (ca > cmax) ca = cmax;
      if (cb > cmax) cb = cmax;
      r[DB-1-j] = (ca > cb);
    end
    return r;
  endfunction

  // Runs one full response from IDLE. mode selects edge pattern; start is
  // re-asserted during offset mid_t (-1 = never). Ends in the cycle after DONE.
  task automatic run_once(input int mode, input int mid_t);
    int j, p, da, db;
    bit a, b, exp_en;
    o_done_t = -1; o_busy = 0; o_ctrl_bad = 0;
    da = 50; db = 50;
    start = 1'b1; ro_a_edge = 1'b0; ro_b_edge = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    o_clr4 = resp4; o_clr2 = resp2;
    for (int t = 0; t <= RUN; t++) begin
      j = (t < RUN) ? t / PER : DB - 1;
      p = t % PER;
      if (busy4) o_busy++;
      if (so4 && o_done_t < 0) o_done_t = t;
      exp_en = (t < RUN) && (p >= S) && (p < S + W);
      if (ro_en4 !== exp_en || sel4 !== SB'(j) || ro_en2 !== ro_en4 || sel2 !== sel4 ||
          busy2 !== busy4 || so2 !== so4) o_ctrl_bad++;
      if (t == RUN) begin o_r4 = resp4; o_r2 = resp2; end
      if (p == 0) begin da = $urandom_range(0, 100); db = $urandom_range(0, 100); end
      case (mode)
        0: begin  // alternating faster oscillator
          a = (j % 2 == 0) ? 1'b1 : (t % 2 == 0);
          b = (j % 2 == 0) ? (t % 2 == 0) : 1'b1;
        end
        1: begin a = 1'b1; b = 1'b1; end
        2: begin a = 1'b1; b = 1'b0; end
        3: begin  // edges only outside MEASURE
          a = !exp_en; b = 1'b0;
        end
        default: begin
          a = ($urandom_range(0, 99) < da);
          b = ($urandom_range(0, 99) < db);
        end
      endcase
      if (t < RUN) begin ea[t] = a; eb[t] = b; end
      ro_a_edge = a; ro_b_edge = b;
      start = (t == mid_t);
      @(posedge clk); #1;
    end
    start = 1'b0; ro_a_edge = 1'b0; ro_b_edge = 1'b0;
    o_idle_ok = !busy4 && !so4 && !ro_en4 && (sel4 == '0) && !busy2 && !so2 && (sel2 == '0);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; ro_a_edge = 1'b0; ro_b_edge = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vec++;
    if ({sel4, ro_en4, busy4, so4, resp4, sel2, ro_en2, busy2, so2, resp2} !== '0) begin
      err++;
      $display("FAIL reset_outputs: got %0h %0h want all zero", {sel4, ro_en4, busy4, so4, resp4},
               {sel2, ro_en2, busy2, so2, resp2});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_alternating;
    run_once(0, -1);
    vec++; if (o_r4 !== 8'hAA) begin err++; $display("FAIL alt_response: got %0h want aa", o_r4); end
    vec++; if (o_r4 !== model(15)) begin err++; $display("FAIL alt_model: got %0h want %0h", o_r4, model(15)); end
    vec++; if (o_done_t !== RUN) begin err++; $display("FAIL alt_start_out_time: got %0d want %0d", o_done_t + 1, RUN + 1); end
    vec++; if (o_busy !== RUN + 1) begin err++; $display("FAIL alt_busy_cycles: got %0d want %0d", o_busy, RUN + 1); end
    vec++; if (o_ctrl_bad !== 0) begin err++; $display("FAIL alt_ctrl_seq: got %0d bad cycles want 0", o_ctrl_bad); end
    vec++; if (o_idle_ok !== 1'b1) begin err++; $display("FAIL alt_idle_after: got %0b want 1", o_idle_ok); end
  endtask

  task automatic test_saturation;
    // Same alternating pattern again on the CNT_BITS=2 instance: 8 vs 4 clip to 3 vs 3.
    run_once(0, -1);
    vec++; if (o_r2 !== 8'h00) begin err++; $display("FAIL sat_response: got %0h want 00", o_r2); end
    vec++; if (o_r2 !== model(3)) begin err++; $display("FAIL sat_model: got %0h want %0h", o_r2, model(3)); end
  endtask

  task automatic test_ties;
    run_once(1, -1);
    vec++; if (o_r4 !== 8'h00) begin err++; $display("FAIL tie_response: got %0h want 00", o_r4); end
    vec++; if (o_clr4 !== 8'h00) begin err++; $display("FAIL tie_clear_on_start: got %0h want 00", o_clr4); end
    run_once(2, -1);
    vec++; if (o_r4 !== 8'hFF) begin err++; $display("FAIL a_only_response4: got %0h want ff", o_r4); end
    vec++; if (o_r2 !== 8'hFF) begin err++; $display("FAIL a_only_response2: got %0h want ff", o_r2); end
  endtask

  task automatic test_start_during_run;
    run_once(2, 30);
    vec++; if (o_done_t !== RUN) begin err++; $display("FAIL mid_start_time: got %0d want %0d", o_done_t + 1, RUN + 1); end
    vec++; if (o_ctrl_bad !== 0) begin err++; $display("FAIL mid_start_ctrl: got %0d bad cycles want 0", o_ctrl_bad); end
    run_once(2, RUN);  // start asserted during DONE
    vec++; if (o_idle_ok !== 1'b1) begin err++; $display("FAIL done_start_ignored: got %0b want 1", o_idle_ok); end
    vec++; if (o_r4 !== 8'hFF) begin err++; $display("FAIL done_start_resp: got %0h want ff", o_r4); end
  endtask

  task automatic test_edges_outside_measure;
    // Leave the block idle one cycle so the previous DONE-cycle start cannot chain.
    @(posedge clk); #1;
    run_once(3, -1);
    vec++; if (o_r4 !== 8'h00) begin err++; $display("FAIL outside_edges4: got %0h want 00", o_r4); end
    vec++; if (o_r2 !== 8'h00) begin err++; $display("FAIL outside_edges2: got %0h want 00", o_r2); end
  endtask

  task automatic test_reset_mid_run;
    logic [SB-1:0] sel_before;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ro_a_edge = 1'b1; ro_b_edge = 1'b0;
    repeat (3 * PER + S + 3) begin @(posedge clk); #1; end
    sel_before = sel4;
    vec++;
    if (sel_before !== SB'(3) || ro_en4 !== 1'b1) begin
      err++; $display("FAIL rst_mid_setup: got sel %0d ro_en %0b want sel 3 ro_en 1", sel_before, ro_en4);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    vec++;
    if ({sel4, ro_en4, busy4, so4, resp4, sel2, ro_en2, busy2, so2, resp2} !== '0) begin
      err++;
      $display("FAIL rst_mid_outputs: got %0h %0h want all zero", {sel4, ro_en4, busy4, so4, resp4},
               {sel2, ro_en2, busy2, so2, resp2});
    end
    rst = 1'b0; ro_a_edge = 1'b0;
    @(posedge clk); #1;
    run_once(0, -1);
    vec++; if (o_done_t !== RUN) begin err++; $display("FAIL rst_rerun_time: got %0d want %0d", o_done_t + 1, RUN + 1); end
    vec++; if (o_r4 !== 8'hAA) begin err++; $display("FAIL rst_rerun_resp: got %0h want aa", o_r4); end
  endtask

  task automatic test_random;
    for (int n = 0; n < 6; n++) begin
      run_once(4, -1);
      vec++; if (o_r4 !== model(15)) begin err++; $display("FAIL rand_resp4 run %0d: got %0h want %0h", n, o_r4, model(15)); end
      vec++; if (o_r2 !== model(3)) begin err++; $display("FAIL rand_resp2 run %0d: got %0h want %0h", n, o_r2, model(3)); end
      vec++; if (o_ctrl_bad !== 0) begin err++; $display("FAIL rand_ctrl run %0d: got %0d want 0", n, o_ctrl_bad); end
    end
  endtask

  task automatic test_back_to_back;
    run_once(2, -1);
    for (int i = 0; i < 5; i++) begin
      ro_a_edge = 1'($urandom_range(0, 1)); ro_b_edge = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      vec++; if (resp4 !== 8'hFF || busy4 !== 1'b0) begin err++; $display("FAIL hold_resp cycle %0d: got %0h busy %0b want ff busy 0", i, resp4, busy4); end
    end
    ro_a_edge = 1'b0; ro_b_edge = 1'b0;
    run_once(0, -1);
    run_once(1, -1);  // starts in the cycle right after the previous DONE
    vec++; if (o_clr4 !== 8'h00) begin err++; $display("FAIL b2b_clear: got %0h want 00", o_clr4); end
    vec++; if (o_done_t !== RUN) begin err++; $display("FAIL b2b_time: got %0d want %0d", o_done_t + 1, RUN + 1); end
    vec++; if (o_r4 !== 8'h00) begin err++; $display("FAIL b2b_resp: got %0h want 00", o_r4); end
  endtask

  initial begin
    test_reset();
    test_alternating();
    test_saturation();
    test_ties();
    test_start_during_run();
    test_edges_outside_measure();
    test_reset_mid_run();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
